// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Round-robin arbiter that is the sole driver of a shared behavioural
//   register's data input and write enable. Each transaction is three cycles:
//   IDLE picks a winner, WRITE holds reg_we active for one cycle, and ACK
//   pulses the winner's gnt once the write has landed.
//
// Parameters
//   N         number of requesters (2..8)
//   W         data width, matches the shared register
//   WE_ACTIVE level of o_reg_we that commands a load (1 high, 0 low)
//
// Ports
//   i_clk      clock, also clocks the shared register
//   i_rst      synchronous active-high reset
//   i_req      [N]   level requests, held until own grant is seen
//   i_data     [N*W] requester i word at i_data[i*W +: W]
//   i_lock     [N]   hold-bus request (REG_ARB_LOCK_EN builds only)
//   o_gnt      [N]   one-hot, one-cycle ack after the write landed
//   o_reg_d    [W]   register data input
//   o_reg_we         register write enable
//   o_busy           high in WRITE and ACK
//   o_last_id        index of the most recent winner
//
// Build option
//   REG_ARB_LOCK_EN: a winner holding lock and req in ACK is granted again at
//   the next decision and the round-robin pointer is not advanced.

// Per-requester eligibility for the upper half of the round-robin search:
// requester IDX is a first-pass candidate when it requests and sits at or
// after the pointer.
module reg_write_arbiter_lane #(
  parameter int N   = 4,
  parameter int IDX = 0
) (
  input  logic                 i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic                 o_hi
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] IDX_V = IW'(IDX);

  assign o_hi = i_req && (IDX_V >= i_ptr);
endmodule

module reg_write_arbiter #(
  parameter int N         = 4,
  parameter int W         = 16,
  parameter int WE_ACTIVE = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N-1:0]         i_req,
  input  logic [N*W-1:0]       i_data,
  input  logic [N-1:0]         i_lock,
  output logic [N-1:0]         o_gnt,
  output logic [W-1:0]         o_reg_d,
  output logic                 o_reg_we,
  output logic                 o_busy,
  output logic [$clog2(N)-1:0] o_last_id
);
  localparam int   IW     = $clog2(N);
  localparam logic WE_ON  = (WE_ACTIVE != 0);
  localparam logic WE_OFF = ~WE_ON;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_ACK} state_t;

  state_t          r_state;
  logic [N-1:0]    r_gnt;
  logic [W-1:0]    r_reg_d;
  logic            r_reg_we;
  logic            r_busy;
  logic [IW-1:0]   r_last_id;
  logic [IW-1:0]   r_ptr;

  logic [N-1:0]    w_hi;
  logic [IW-1:0]   w_pick_hi;
  logic [IW-1:0]   w_pick_any;
  logic [IW-1:0]   w_pick;
  logic [W-1:0]    w_word;
  logic [IW-1:0]   w_ptr_next;

  // Upper-half candidates, one lane per requester.
  for (genvar g = 0; g < N; g++) begin : g_lane
    reg_write_arbiter_lane #(.N(N), .IDX(g)) u_lane (
      .i_req (i_req[g]),
      .i_ptr (r_ptr),
      .o_hi  (w_hi[g])
    );
  end

`ifdef REG_ARB_LOCK_EN
  logic r_lock_hold;
`else
  // Lock is not part of this build; fold it away quietly.
  logic w_unused_lock;
  assign w_unused_lock = ^i_lock;
`endif

  // First set bit at or above the pointer; if none, wrap to the lowest
  // requester overall. Loops run downward so the lowest index wins.
  always_comb begin
    w_pick_hi  = '0;
    w_pick_any = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_hi[i])  w_pick_hi  = IW'(i);
      if (i_req[i]) w_pick_any = IW'(i);
    end
    w_pick = (|w_hi) ? w_pick_hi : w_pick_any;
`ifdef REG_ARB_LOCK_EN
    // A held lock overrides the pointer as long as the owner still requests.
    if (r_lock_hold && i_req[r_last_id]) w_pick = r_last_id;
`endif
  end

  assign w_word     = i_data[int'(w_pick)*W +: W];
  assign w_ptr_next = (r_last_id == IW'(N - 1)) ? '0 : r_last_id + IW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_reg_d   <= '0;
      r_reg_we  <= WE_OFF;
      r_busy    <= 1'b0;
      r_last_id <= '0;
      r_ptr     <= '0;
`ifdef REG_ARB_LOCK_EN
      r_lock_hold <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            // The word is captured here; later data changes are ignored.
            r_reg_d   <= w_word;
            r_last_id <= w_pick;
            r_reg_we  <= WE_ON;
            r_busy    <= 1'b1;
            r_state   <= S_WRITE;
`ifdef REG_ARB_LOCK_EN
            r_lock_hold <= 1'b0;
`endif
          end
        end
        S_WRITE: begin
          // The register loads o_reg_d on this edge.
          r_reg_we <= WE_OFF;
          r_gnt    <= {{(N-1){1'b0}}, 1'b1} << r_last_id;
          r_state  <= S_ACK;
        end
        S_ACK: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
`ifdef REG_ARB_LOCK_EN
          if (i_lock[r_last_id] && i_req[r_last_id]) begin
            r_lock_hold <= 1'b1;
          end else begin
            r_lock_hold <= 1'b0;
            r_ptr       <= w_ptr_next;
          end
`else
          r_ptr <= w_ptr_next;
`endif
        end
        default: begin
          r_state  <= S_IDLE;
          r_gnt    <= '0;
          r_reg_we <= WE_OFF;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_reg_d   = r_reg_d;
  assign o_reg_we  = r_reg_we;
  assign o_busy    = r_busy;
  assign o_last_id = r_last_id;
endmodule
